// File: rtl/sd_clk_ctrl.sv
// SD card clock controller: free-running divider, power-up init clocks,
// glitch-free slow/fast switching, stop/restart and iclk-domain edge strobes.
module sd_clk_ctrl #(
  parameter int SLOW_DIV_LOG2 = 7,
  parameter int INIT_CYCLES   = 80
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic isel_clk,
  input  logic istop,
  output logic oclk_sd,
  output logic orise,
  output logic ofall,
  output logic osel_ack,
  output logic ostopped,
  output logic oinit_done
);

  localparam int CW = SLOW_DIV_LOG2 - 1;
  localparam int EW = $clog2(INIT_CYCLES + 1);

  typedef enum logic [1:0] {S_INIT, S_RUN, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   edges_q, edges_d;
  logic            clk_q, clk_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic            sel_q, sel_d;
  logic            stop_q, done_q;
  logic            tick;

  // Slow ticks land on the last count so each half-period is exactly 2^CW cycles.
  assign tick = sel_q | (&cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    edges_d = edges_q;
    clk_d   = clk_q;
    sel_d   = sel_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_INIT: begin
        if (tick) begin
          clk_d  = ~clk_q;
          rise_d = ~clk_q;
          fall_d = clk_q;
          if (!clk_q && edges_q != EW'(INIT_CYCLES)) edges_d = edges_q + 1'b1;
          if (clk_q && edges_q == EW'(INIT_CYCLES)) state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (istop && !clk_q) begin
          // Parking while low: any rising tick this cycle is swallowed.
          state_d = S_STOP;
          cnt_d   = '0;
        end else if (tick) begin
          clk_d  = ~clk_q;
          rise_d = ~clk_q;
          fall_d = clk_q;
          if (clk_q) begin
            // Rate changes only at a fall so the following low phase is whole.
            if (isel_clk != sel_q) begin
              sel_d = isel_clk;
              cnt_d = '0;
            end
            if (istop) begin
              state_d = S_STOP;
              cnt_d   = '0;
            end
          end
        end
      end
      S_STOP: begin
        cnt_d = '0;
        sel_d = isel_clk;
        if (!istop) state_d = S_RUN;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      edges_q <= '0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      sel_q   <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edges_q <= edges_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      sel_q   <= sel_d;
      stop_q  <= (state_q == S_STOP);
      done_q  <= done_q | (state_q != S_INIT);
    end
  end

  assign oclk_sd    = clk_q;
  assign orise      = rise_q;
  assign ofall      = fall_q;
  assign osel_ack   = sel_q;
  assign ostopped   = stop_q;
  assign oinit_done = done_q;

endmodule

// File: doc/sd_clk_ctrl.md
Name: sd_clk_ctrl

Overview:
Controller for the SD card clock. It generates oclk_sd from a free-running divider and runs the power-up init sequence of INIT_CYCLES slow clocks. It switches glitch-free between slow and fast rates, and stops/restarts the card clock on request from the command/data FSMs. It also issues single-cycle rise/fall strobes in the iclk domain so SD logic samples and drives without using oclk_sd as a clock.

Parameters:
SLOW_DIV_LOG2, 7, slow SD clock period is 2^SLOW_DIV_LOG2 iclk cycles (128 → half-period 64)
INIT_CYCLES, 80, number of slow rising edges issued after reset before oinit_done (SD spec minimum is 74)

Ports:
iclk  input  1  reference clock; all logic on posedge
irst_n  input  1  asynchronous active-low reset
isel_clk  input  1  requested rate: 0 slow, 1 fast (level)
istop  input  1  request clock stop, held low (level)
oclk_sd  output  1  registered SD card clock
orise  output  1  one-iclk strobe, first cycle oclk_sd is 1
ofall  output  1  one-iclk strobe, first cycle oclk_sd is 0 after a high phase
osel_ack  output  1  rate currently in effect (0 slow, 1 fast)
ostopped  output  1  clock is parked low on istop
oinit_done  output  1  init sequence complete (sticky until reset)

Behaviour:
- Reset (irst_n=0, async): counter=0, oclk_sd=0, orise=0, ofall=0, osel_ack=0, ostopped=0, oinit_done=0, state=INIT, edge count=0.
- Internal counter: SLOW_DIV_LOG2-1 bits, increments every cycle, wraps. Counter resets to 0 on every rate switch and on exit from STOPPED.
- tick: fast mode → every cycle; slow mode → counter at all ones (every 64 cycles by default).
- On tick while running: oclk_sd toggles. orise/ofall are registered with oclk_sd, so they are high in exactly the cycle the new level first appears.
- Fast clock: period 2 iclk, 50% duty. Slow clock: period 128 iclk, 50% duty.
- States:
  - INIT: slow mode forced; isel_clk and istop ignored. Count rising edges. After the INIT_CYCLES-th rise, the next falling tick → RUN, and oinit_done=1 from the following cycle.
  - RUN: clock runs at the osel_ack rate.
    - Rate switch: when isel_clk != osel_ack, the switch is applied only on a falling tick (oclk_sd 1→0). That cycle: osel_ack<=isel_clk, counter<=0. The low phase that follows uses the new rate. No phase is ever shorter than one iclk cycle, and no runt pulse occurs.
    - Stop: if istop=1 and oclk_sd=0 → STOPPED immediately. Any rising tick that cycle is suppressed, so there is no orise. If oclk_sd=1, wait for the falling tick, then STOPPED in the same cycle. ostopped=1 from the cycle after entry.
  - STOPPED: oclk_sd held 0, no strobes, counter held at 0. osel_ack follows isel_clk directly (registered, one cycle). When istop=0 → RUN, ostopped=0 next cycle. The first rising edge comes one full half-period of the current rate later.
- Simultaneous events:
  - istop and a pending rate switch on the same falling tick: both take effect.
  - isel_clk toggling back before a falling tick: no switch occurs.
  - istop deasserted in the same cycle as entry: one STOPPED cycle minimum.
- Reset mid-operation returns to INIT immediately. oclk_sd drops to 0 asynchronously, and the full init sequence repeats.

Test Plan:
1. Release reset with isel_clk=1 and istop=1 → both ignored. 80 slow rises, first at iclk cycle 64, then every 128. oinit_done rises 1 cycle after the 80th fall (~cycle 10241). Exactly 80 orise and 80 ofall pulses.
2. After init, isel_clk=1 mid high phase → rate is unchanged until the falling tick. Then osel_ack=1, oclk_sd period 2, no high phase shorter than 1 cycle. isel_clk=0 → returns to period 128 at the next fall.
3. Fast mode, istop=1 while oclk_sd=1 → stops at the falling tick, ostopped=1 the next cycle, oclk_sd stays 0 for 50 cycles. istop=0 → first orise 1 cycle after restart (fast half-period).
4. Slow mode, istop=1 while oclk_sd=0 on the cycle of a rising tick → no rise, ostopped=1. Toggle isel_clk=1 while stopped → osel_ack=1. Release → fast clock.
5. Assert irst_n=0 during fast running → oclk_sd=0, all outputs at reset values asynchronously. Release → init sequence repeats with oinit_done=0 until complete.
6. Pulse isel_clk 1 for 10 cycles within a slow high phase → no switch, osel_ack stays 0, period stays 128.
